// File: rtl/sap3_ctrl_pkg.sv
// SAP-3 control sequencer shared definitions: opcodes, ALU ops,
// control-word layout and per-opcode step counts.
package sap3_ctrl_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_MVI = 8'h3E;
    localparam logic [7:0] OP_LDA = 8'h3A;
    localparam logic [7:0] OP_STA = 8'h32;
    localparam logic [7:0] OP_ADD = 8'h80;
    localparam logic [7:0] OP_SUB = 8'h90;
    localparam logic [7:0] OP_INR = 8'h3C;
    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_JZ  = 8'hCA;
    localparam logic [7:0] OP_OUT = 8'hD3;
    localparam logic [7:0] OP_HLT = 8'h76;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_INC  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    localparam int CW_PC_OE    = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_WE   = 3;
    localparam int CW_MEM_OE   = 4;
    localparam int CW_MEM_WE   = 5;
    localparam int CW_IR_WE    = 6;
    localparam int CW_Z_WE     = 7;
    localparam int CW_W_WE     = 8;
    localparam int CW_WZ_OE    = 9;
    localparam int CW_A_WE     = 10;
    localparam int CW_A_OE     = 11;
    localparam int CW_ALU_OE   = 12;
    localparam int CW_FLAGS_WE = 13;
    localparam int CW_OUT_WE   = 14;
    localparam int CW_ALU      = 15;
    localparam int CW_W        = 17;

    typedef logic [CW_W-1:0] cw_t;

    // Total T-steps including the two fetch steps; unknown opcodes run as NOP.
    function automatic logic [3:0] op_steps(input logic [7:0] op);
        case (op)
            OP_MVI:         op_steps = 4'd4;
            OP_OUT:         op_steps = 4'd5;
            OP_JMP, OP_JZ:  op_steps = 4'd7;
            OP_LDA, OP_STA: op_steps = 4'd8;
            default:        op_steps = 4'd3;
        endcase
    endfunction

endpackage

// File: rtl/sap3_ucode.sv
// Combinational microcode decoder: (t, ir, flag_z) -> control word
// plus a flag marking the final step of the instruction.
module sap3_ucode
    import sap3_ctrl_pkg::*;
#(
    parameter int TW = 3
) (
    input  logic [TW-1:0] t,
    input  logic [7:0]    ir,
    input  logic          flag_z,
    output cw_t           cw,
    output logic          last
);

    int   tn;
    logic opzw;

    assign tn   = int'(t);
    assign opzw = (ir == OP_LDA) || (ir == OP_STA) ||
                  (ir == OP_JMP) || (ir == OP_JZ);

    always_comb begin
        cw   = '0;
        last = 1'b0;
        if (tn == 0) begin
            cw[CW_PC_OE]  = 1'b1;
            cw[CW_MAR_WE] = 1'b1;
        end else if (tn == 1) begin
            cw[CW_MEM_OE] = 1'b1;
            cw[CW_IR_WE]  = 1'b1;
            cw[CW_PC_INC] = 1'b1;
        end else begin
            last = (tn == int'(op_steps(ir)) - 1);
            if (opzw) begin
                case (tn)
                    2, 4: begin
                        cw[CW_PC_OE]  = 1'b1;
                        cw[CW_MAR_WE] = 1'b1;
                    end
                    3, 5: begin
                        cw[CW_MEM_OE] = 1'b1;
                        cw[CW_PC_INC] = 1'b1;
                        cw[CW_Z_WE]   = (tn == 3);
                        cw[CW_W_WE]   = (tn == 5);
                    end
                    6: begin
                        cw[CW_WZ_OE]   = 1'b1;
                        cw[CW_MAR_WE]  = (ir == OP_LDA) || (ir == OP_STA);
                        cw[CW_PC_LOAD] = (ir == OP_JMP) ||
                                         ((ir == OP_JZ) && flag_z);
                    end
                    7: begin
                        cw[CW_MEM_OE] = (ir == OP_LDA);
                        cw[CW_A_WE]   = (ir == OP_LDA);
                        cw[CW_A_OE]   = (ir == OP_STA);
                        cw[CW_MEM_WE] = (ir == OP_STA);
                    end
                    default: ;
                endcase
            end else begin
                case (ir)
                    OP_MVI, OP_OUT: begin
                        if (tn == 2) begin
                            cw[CW_PC_OE]  = 1'b1;
                            cw[CW_MAR_WE] = 1'b1;
                        end else if (tn == 3) begin
                            cw[CW_MEM_OE] = 1'b1;
                            cw[CW_PC_INC] = 1'b1;
                            cw[CW_A_WE]   = (ir == OP_MVI);
                            cw[CW_Z_WE]   = (ir == OP_OUT);
                        end else if (tn == 4 && ir == OP_OUT) begin
                            cw[CW_A_OE]   = 1'b1;
                            cw[CW_OUT_WE] = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB, OP_INR: begin
                        if (tn == 2) begin
                            cw[CW_ALU_OE]   = 1'b1;
                            cw[CW_A_WE]     = 1'b1;
                            cw[CW_FLAGS_WE] = 1'b1;
                            cw[CW_ALU+:2]   = (ir == OP_ADD) ? ALU_ADD :
                                              (ir == OP_SUB) ? ALU_SUB :
                                                               ALU_INC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sap3_control.sv
// SAP-3 control sequencer: T-state counter, halt latch and
// gating of the microcode control word onto the datapath strobes.
module sap3_control
    import sap3_ctrl_pkg::*;
#(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ir,
    input  logic          flag_z,
    output logic          pc_oe,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          mar_we,
    output logic          mem_oe,
    output logic          mem_we,
    output logic          ir_we,
    output logic          z_we,
    output logic          w_we,
    output logic          wz_oe,
    output logic          a_we,
    output logic          a_oe,
    output logic          alu_oe,
    output logic          flags_we,
    output logic [1:0]    alu_op,
    output logic          out_we,
    output logic [TW-1:0] t_state,
    output logic          halted
);

    logic [TW-1:0] t;
    logic          hlt;
    logic          last;
    cw_t           cw;
    cw_t           cwg;

    sap3_ucode #(.TW(TW)) u_ucode (
        .t      (t),
        .ir     (ir),
        .flag_z (flag_z),
        .cw     (cw),
        .last   (last)
    );

    // HLT ends at T2 but parks the counter there instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t   <= '0;
            hlt <= 1'b0;
        end else if (!hlt) begin
            if (last && ir == OP_HLT) begin
                hlt <= 1'b1;
            end else if (last) begin
                t <= '0;
            end else begin
                t <= t + 1'b1;
            end
        end
    end

    assign cwg = (rst || hlt) ? '0 : cw;

    assign pc_oe    = cwg[CW_PC_OE];
    assign pc_inc   = cwg[CW_PC_INC];
    assign pc_load  = cwg[CW_PC_LOAD];
    assign mar_we   = cwg[CW_MAR_WE];
    assign mem_oe   = cwg[CW_MEM_OE];
    assign mem_we   = cwg[CW_MEM_WE];
    assign ir_we    = cwg[CW_IR_WE];
    assign z_we     = cwg[CW_Z_WE];
    assign w_we     = cwg[CW_W_WE];
    assign wz_oe    = cwg[CW_WZ_OE];
    assign a_we     = cwg[CW_A_WE];
    assign a_oe     = cwg[CW_A_OE];
    assign alu_oe   = cwg[CW_ALU_OE];
    assign flags_we = cwg[CW_FLAGS_WE];
    assign alu_op   = cwg[CW_ALU+:2];
    assign out_we   = cwg[CW_OUT_WE];
    assign t_state  = t;
    assign halted   = hlt;

endmodule

// File: tb/tb_sap3_control.sv
// Self-checking bench for sap3_control: per-opcode step tables plus
// reset, halt and mid-instruction reset sequences via a scoreboard.
module tb_sap3_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       flag_z = 1'b0;
    logic       pc_oe, pc_inc, pc_load, mar_we, mem_oe, mem_we, ir_we;
    logic       z_we, w_we, wz_oe, a_we, a_oe, alu_oe, flags_we, out_we;
    logic [1:0] alu_op;
    logic [2:0] t_state;
    logic       halted;

    always #5 clk = ~clk;

    sap3_control #(.TW(3)) dut (
        .clk(clk), .rst(rst), .ir(ir), .flag_z(flag_z),
        .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_we(mar_we), .mem_oe(mem_oe), .mem_we(mem_we),
        .ir_we(ir_we), .z_we(z_we), .w_we(w_we), .wz_oe(wz_oe),
        .a_we(a_we), .a_oe(a_oe), .alu_oe(alu_oe),
        .flags_we(flags_we), .alu_op(alu_op), .out_we(out_we),
        .t_state(t_state), .halted(halted)
    );

    localparam logic [16:0] PC_OE  = 17'h00001;
    localparam logic [16:0] PC_INC = 17'h00002;
    localparam logic [16:0] PC_LD  = 17'h00004;
    localparam logic [16:0] MAR    = 17'h00008;
    localparam logic [16:0] MEM_OE = 17'h00010;
    localparam logic [16:0] MEM_WE = 17'h00020;
    localparam logic [16:0] IR_WE  = 17'h00040;
    localparam logic [16:0] Z_WE   = 17'h00080;
    localparam logic [16:0] W_WE   = 17'h00100;
    localparam logic [16:0] WZ_OE  = 17'h00200;
    localparam logic [16:0] A_WE   = 17'h00400;
    localparam logic [16:0] A_OE   = 17'h00800;
    localparam logic [16:0] ALU_OE = 17'h01000;
    localparam logic [16:0] FL_WE  = 17'h02000;
    localparam logic [16:0] OUT_WE = 17'h04000;
    localparam logic [16:0] OP_SUB = 17'h08000;
    localparam logic [16:0] OP_INC = 17'h10000;
    localparam logic [16:0] F0     = PC_OE | MAR;
    localparam logic [16:0] F1     = MEM_OE | IR_WE | PC_INC;
    localparam logic [16:0] OPZ    = MEM_OE | Z_WE | PC_INC;
    localparam logic [16:0] OPW    = MEM_OE | W_WE | PC_INC;

    wire [16:0] got = {alu_op, out_we, flags_we, alu_oe, a_oe, a_we,
                       wz_oe, w_we, z_we, ir_we, mem_we, mem_oe,
                       mar_we, pc_load, pc_inc, pc_oe};

    typedef struct {
        logic [2:0]  t;
        logic [16:0] w;
        logic        h;
    } exp_t;

    typedef struct {
        string           name;
        logic [7:0]      op;
        logic            z;
        int              n;
        logic [7:0][16:0] w;
    } vec_t;

    exp_t q[$];
    exp_t e;
    vec_t tbl[12];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_we_seen = 0;
    bit   watch = 1'b0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (t_state !== e.t || got !== e.w || halted !== e.h) begin
                n_bad++;
                $display("FAIL step @%0t: got t=%0d cw=%h halted=%b, want t=%0d cw=%h halted=%b",
                         $time, t_state, got, halted, e.t, e.w, e.h);
            end
        end
        n_cmp++;
        if ($countones({pc_oe, mem_oe, a_oe, alu_oe}) > 1) begin
            n_bad++;
            $display("FAIL bus_onehot @%0t: drivers=%b, want at most one",
                     $time, {pc_oe, mem_oe, a_oe, alu_oe});
        end
        if (watch && mem_we === 1'b1) mem_we_seen++;
    end

    function automatic vec_t mkv(input string nm, input logic [7:0] op,
                                 input logic z, input int n,
                                 input logic [16:0] w2, input logic [16:0] w3,
                                 input logic [16:0] w4, input logic [16:0] w5,
                                 input logic [16:0] w6, input logic [16:0] w7);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.z    = z;
        v.n    = n;
        v.w    = {w7, w6, w5, w4, w3, w2, F1, F0};
        return v;
    endfunction

    task automatic cyc(input logic [2:0] et, input logic [16:0] ew,
                       input logic eh);
        q.push_back('{t: et, w: ew, h: eh});
        @(posedge clk);
        #1;
    endtask

    // flag_z is held at the opposite value outside T6 to show it is ignored.
    task automatic run(input vec_t v, input int nsteps);
        for (int s = 0; s < nsteps; s++) begin
            if (s == 2) ir = v.op;
            if (s >= 2) flag_z = (s == 6) ? v.z : ~v.z;
            cyc(3'(s), v.w[s], 1'b0);
        end
    endtask

    initial begin
        tbl[0]  = mkv("nop", 8'h00, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv("mvi", 8'h3E, 0, 4, F0, MEM_OE | A_WE | PC_INC, 0, 0, 0, 0);
        tbl[2]  = mkv("lda", 8'h3A, 0, 8, F0, OPZ, F0, OPW, WZ_OE | MAR, MEM_OE | A_WE);
        tbl[3]  = mkv("sta", 8'h32, 1, 8, F0, OPZ, F0, OPW, WZ_OE | MAR, A_OE | MEM_WE);
        tbl[4]  = mkv("add", 8'h80, 0, 3, ALU_OE | A_WE | FL_WE, 0, 0, 0, 0, 0);
        tbl[5]  = mkv("sub", 8'h90, 1, 3, ALU_OE | A_WE | FL_WE | OP_SUB, 0, 0, 0, 0, 0);
        tbl[6]  = mkv("inr", 8'h3C, 0, 3, ALU_OE | A_WE | FL_WE | OP_INC, 0, 0, 0, 0, 0);
        tbl[7]  = mkv("jmp", 8'hC3, 0, 7, F0, OPZ, F0, OPW, WZ_OE | PC_LD, 0);
        tbl[8]  = mkv("jz1", 8'hCA, 1, 7, F0, OPZ, F0, OPW, WZ_OE | PC_LD, 0);
        tbl[9]  = mkv("jz0", 8'hCA, 0, 7, F0, OPZ, F0, OPW, WZ_OE, 0);
        tbl[10] = mkv("out", 8'hD3, 0, 5, F0, OPZ, A_OE | OUT_WE, 0, 0, 0);
        tbl[11] = mkv("ill", 8'h47, 1, 3, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(3'd0, 17'h0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run(tbl[i], tbl[i].n);

        cyc(3'd0, F0, 1'b0);
        cyc(3'd1, F1, 1'b0);
        ir = 8'h76;
        cyc(3'd2, 17'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ir     = 8'($urandom);
            flag_z = 1'($urandom);
            cyc(3'd2, 17'h0, 1'b1);
        end
        rst = 1'b1;
        cyc(3'd0, 17'h0, 1'b0);
        cyc(3'd0, 17'h0, 1'b0);
        rst = 1'b0;
        ir  = 8'h00;
        run(tbl[0], tbl[0].n);

        watch = 1'b1;
        run(tbl[3], 4);
        rst = 1'b1;
        cyc(3'd0, 17'h0, 1'b0);
        rst = 1'b0;
        run(tbl[0], tbl[0].n);
        run(tbl[4], tbl[4].n);
        watch = 1'b0;
        n_cmp++;
        if (mem_we_seen != 0) begin
            n_bad++;
            $display("FAIL sta_abort_mem_we: got %0d writes, want 0", mem_we_seen);
        end

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
